// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, default bit period and the
// arbiter FSM state encoding used by the TX arbiter and future RX logic.
package uart_pkg;

  localparam int UART_BYTE_W  = 8;
  localparam int CLKS_PER_BIT = 5208;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

endpackage : uart_pkg

// File: rtl/uart_rr_pick.sv
// Combinational round-robin priority picker: finds the first set bit of
// req_vec searching upward from ptr with wrap-around. Returns the winner
// both one-hot (gnt) and as an index (gnt_idx). gnt is all-zero when
// req_vec is empty. ptr must be below NUM_REQ.
module uart_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_vec,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  // Scan requesters in priority order starting at ptr; first hit wins.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] idx;
    // NOTE: every output gets a default before the loop so no path leaves
    // a value unassigned; that is what keeps this block free of latches.
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req_vec[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

endmodule : uart_rr_pick

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers.
// A requester is accepted in IDLE, its byte is issued with a one-cycle
// tx_start, and the grant is held until tx_done returns.
// Optional feature macro: UART_ARB_TIMEOUT_EN adds a WAIT_DONE watchdog
// and the sticky timeout_err output.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int TIMEOUT_CYCLES = 60000,
  localparam int IDX_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_start,
  output logic [UART_BYTE_W-1:0]         tx_data,
  input  logic                           tx_busy,
  input  logic                           tx_done,
  output logic [IDX_W-1:0]               grant_id,
  output logic                           arb_busy,
  output logic [NUM_REQ-1:0]             frame_done
`ifdef UART_ARB_TIMEOUT_EN
 ,output logic                           timeout_err
`endif
);

  // Elaboration-time parameter sanity checks.
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be in 2..16");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_e               state;
  logic [IDX_W-1:0]         ptr;
  logic [NUM_REQ-1:0]       pick_gnt;
  logic [IDX_W-1:0]         pick_idx;
  logic [IDX_W-1:0]         next_ptr;
  logic [UART_BYTE_W-1:0]   pick_data;
  logic [NUM_REQ-1:0]       grant_onehot;
  logic                     accept;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 16) ? $clog2(TIMEOUT_CYCLES) : 16;
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wd_cnt;
`endif

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_vec (req_valid),
    .ptr     (ptr),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx)
  );

  // Offer the picked requester only when idle, uart_tx is free and out of reset.
  assign req_ready = (rst_n && (state == IDLE) && !tx_busy) ? pick_gnt : '0;
  assign accept    = |req_ready;

  // Pointer moves just past the winner so it gets lowest priority next time.
  assign next_ptr = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

  assign grant_onehot = NUM_REQ'(1) << grant_id;

  // Select the winner's byte from the packed request bus.
  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) pick_data = req_data[i*UART_BYTE_W +: UART_BYTE_W];
    end
  end

  // Arbiter FSM with registered outputs; tx_start is high only in ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      arb_busy    <= 1'b0;
      frame_done  <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples the pre-edge values and the defaults below are simply
      // overridden by later assignments in the same edge.
      tx_start   <= 1'b0;
      frame_done <= '0;
      unique case (state)
        IDLE: begin
          // A stray tx_done here is ignored.
          if (accept) begin
            tx_data  <= pick_data;
            grant_id <= pick_idx;
            ptr      <= next_ptr;
            arb_busy <= 1'b1;
            tx_start <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef UART_ARB_TIMEOUT_EN
          wd_cnt <= '0;
`endif
          state  <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done) begin
            frame_done <= grant_onehot;
            arb_busy   <= 1'b0;
            state      <= IDLE;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (wd_cnt == WD_LIMIT) begin
            timeout_err <= 1'b1;
            frame_done  <= grant_onehot;
            arb_busy    <= 1'b0;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (default build, NUM_REQ=4).
// The uart_tx side is emulated in the stimulus; expected winners come from
// a distance-from-pointer reference model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [8*N-1:0]  req_data;
  logic [N-1:0]    req_ready;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_busy;
  logic            tx_done;
  logic [IW-1:0]   grant_id;
  logic            arb_busy;
  logic [N-1:0]    frame_done;

  int vectors     = 0;
  int miscompares = 0;
  int ref_ptr     = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(60000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .grant_id   (grant_id),
    .arb_busy   (arb_busy),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner = pending requester with the smallest upward distance from ptr.
  function automatic int ref_pick(input logic [N-1:0] v, input int p);
    int best;
    int best_dist;
    int d;
    best      = -1;
    best_dist = N;
    for (int i = 0; i < N; i++) begin
      d = (i - p + N) % N;
      if (v[i] && d < best_dist) begin
        best_dist = d;
        best      = i;
      end
    end
    return best;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"},   32'(tx_start),   32'd0);
    check({tag, "_tx_data"},    32'(tx_data),    32'd0);
    check({tag, "_grant_id"},   32'(grant_id),   32'd0);
    check({tag, "_arb_busy"},   32'(arb_busy),   32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_req_ready"},  32'(req_ready),  32'd0);
  endtask

  // One complete frame from accept to frame_done; req_valid must be nonzero.
  task automatic run_frame(input int done_delay, input logic [N-1:0] valid_at_d);
    int         w;
    logic [7:0] b;
    #1;
    w = ref_pick(req_valid, ref_ptr);
    b = req_data[w*8 +: 8];
    check("ready_onehot", 32'(req_ready), 32'(1) << w);
    tick();                                   // T+1: ISSUE
    check("start_pulse", 32'(tx_start), 32'd1);
    check("tx_data",     32'(tx_data),  32'(b));
    check("grant_id",    32'(grant_id), 32'(w));
    check("arb_busy_on", 32'(arb_busy), 32'd1);
    check("ready_issue", 32'(req_ready), 32'd0);
    ref_ptr = (w + 1) % N;
    req_data[w*8 +: 8] = 8'($urandom);        // producer's next byte
    tick();                                   // T+2: uart_tx now busy
    tx_busy = 1'b1;
    check("start_single", 32'(tx_start), 32'd0);
    for (int c = 1; c < done_delay; c++) begin
      tick();
      check("start_quiet", 32'(tx_start),  32'd0);
      check("ready_wait",  32'(req_ready), 32'd0);
      check("data_hold",   32'(tx_data),   32'(b));
    end
    tick();                                   // D: tx_done
    tx_done   = 1'b1;
    tx_busy   = 1'b0;
    req_valid = valid_at_d;
    #1;
    check("no_accept_at_done", 32'(req_ready), 32'd0);
    tick();                                   // D+1
    tx_done = 1'b0;
    check("frame_done",   32'(frame_done), 32'(1) << w);
    check("arb_busy_off", 32'(arb_busy),   32'd0);
    check("grant_kept",   32'(grant_id),   32'(w));
  endtask

  initial begin
    logic [IW-1:0] order [5];
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    rst_n     = 1'b0;
    req_valid = '1;
    req_data  = '0;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = '0;
    tick();

    // Single request from requester 2.
    req_valid = 4'b0100;
    req_data  = 32'h00A5_0000;
    run_frame(3, 4'b0000);
    check("single_ptr_grant", 32'(grant_id), 32'd2);

    // Reset to restart the pointer, then all four continuously valid.
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset2");
    @(negedge clk);
    rst_n   = 1'b1;
    ref_ptr = 0;
    for (int i = 0; i < N; i++) req_data[i*8 +: 8] = 8'($urandom);
    req_valid = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      run_frame(int'($urandom_range(1, 5)), (f == 4) ? 4'b0000 : 4'b1111);
      check("rr_order", 32'(grant_id), 32'(order[f]));
    end

    // tx_done in the same cycle as a new req_valid[1]: accepted one cycle later.
    req_valid = 4'b0001;
    run_frame(2, 4'b0010);
    #1;
    check("late_accept_ready", 32'(req_ready), 32'b0010);
    run_frame(2, 4'b0000);

    // A stray tx_done while idle is ignored.
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("idle_done_ignored", 32'(frame_done), 32'd0);
    check("idle_busy_low",     32'(arb_busy),   32'd0);

    // Randomised frames, some held back by tx_busy with a changing request.
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < N; i++) req_data[i*8 +: 8] = 8'($urandom);
      req_valid = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0) begin
        tx_busy = 1'b1;
        #1;
        check("ready_gated_busy", 32'(req_ready), 32'd0);
        tick();
        req_valid = 4'($urandom_range(1, 15));
        tx_busy   = 1'b0;
      end
      run_frame(int'($urandom_range(1, 6)), req_valid);
    end

    // Reset in the middle of a frame granted to requester 3.
    req_valid = 4'b1000;
    #1;
    check("mid_ready3", 32'(req_ready), 32'b1000);
    tick();
    tick();
    tx_busy = 1'b1;
    tick();
    check("mid_grant3", 32'(grant_id), 32'd3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    tx_busy   = 1'b0;
    req_valid = 4'b1001;
    @(negedge clk);
    rst_n   = 1'b1;
    ref_ptr = 0;
    run_frame(2, 4'b0000);
    check("post_reset_first", 32'(grant_id), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_uart_tx_arbiter

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` transmitter between `NUM_REQ` byte producers. Each requester offers a byte over a valid/ready handshake. The arbiter grants one requester at a time, issues the byte to `uart_tx` with a single-cycle `tx_start`, then holds the grant until `tx_done` returns. It sits between the system's message sources and the shared `uart_tx` instance.

## Interface
- `NUM_REQ`, 4: number of requesters, legal range 2..16.
- `TIMEOUT_CYCLES`, 60000: watchdog limit in clock cycles. Only used with `UART_ARB_TIMEOUT_EN`. Must exceed 10×`CLKS_PER_BIT` of the attached `uart_tx`.
- `clk` in 1: system clock. One clock; reset is asynchronous and active-low.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in `NUM_REQ`: requester i has a byte pending.
- `req_data` in 8×`NUM_REQ`: byte of requester i in bits [8i+7:8i].
- `req_ready` out `NUM_REQ`: one-hot accept. A transfer occurs when `req_valid[i] & req_ready[i]`.
- `tx_start` out 1: one-cycle start pulse to `uart_tx`.
- `tx_data` out 8: byte to `uart_tx`, held stable from `tx_start` until `tx_done`.
- `tx_busy` in 1: from `uart_tx`.
- `tx_done` in 1: one-cycle completion pulse from `uart_tx`.
- `grant_id` out clog2(`NUM_REQ`): index of the current or last granted requester.
- `arb_busy` out 1: high from the accept cycle until the cycle after `tx_done`.
- `frame_done` out `NUM_REQ`: one-cycle pulse to the granted requester when its frame completes.
- `timeout_err` out 1: sticky error flag. Only present with the macro.

## Operation
- FSM states: IDLE, ISSUE, WAIT_DONE. Reset enters IDLE.
- **IDLE**
  - When `tx_busy`=0, `req_ready` = one-hot of the first `req_valid` bit found searching upward, with wrap, from `ptr`.
  - `ptr` starts at 0 and is set to (winner+1) mod `NUM_REQ` on each accept.
  - `req_ready` is combinational from state, `req_valid`, `ptr` and `tx_busy`. It is 0 outside IDLE and 0 while `tx_busy`=1.
  - On accept: register `tx_data` = byte, register `grant_id` = winner, set `arb_busy`=1, go to ISSUE.
- **ISSUE**: `tx_start`=1 for exactly this cycle, then go to WAIT_DONE.
- **WAIT_DONE**
  - On `tx_done`: pulse `frame_done[grant_id]` in the next cycle, clear `arb_busy`, go to IDLE.
  - `tx_start` stays 0 throughout.
- **Fairness**: a requester holding `req_valid` continuously waits at most `NUM_REQ`-1 frames.
- **Ignored inputs**: a `tx_done` arriving in IDLE or ISSUE is ignored. A `req_valid` deassertion before accept is legal.
- **Reset mid-frame**: all registers return to reset values immediately. Any partially transmitted frame is not retried.

## Timing
- Reset values:
  - `tx_start`=0, `tx_data`=0, `grant_id`=0, `arb_busy`=0, `frame_done`=0, `timeout_err`=0.
  - `req_ready`=0 while `rst_n`=0.
- Accept cycle T (valid&ready) → `tx_start` at T+1 → `uart_tx` asserts `tx_busy` at T+2.
- `tx_done` at cycle D → `frame_done` and return to IDLE at D+1. The earliest next accept is D+1, so the back-to-back gap is 2 cycles.
- `tx_done` coinciding with new `req_valid`: the request is accepted at D+1, never at D.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A 16+ bit counter clears on ISSUE and increments in WAIT_DONE.
  - When it reaches `TIMEOUT_CYCLES`-1 without `tx_done`: set `timeout_err` (sticky until reset), pulse `frame_done[grant_id]`, return to IDLE.
- Undefined: no counter and no `timeout_err` port. WAIT_DONE waits indefinitely.

## Structure
- Shared package `uart_pkg`:
  - state encoding constants: IDLE=2'd0, ISSUE=2'd1, WAIT_DONE=2'd2
  - `UART_BYTE_W`=8
  - default `CLKS_PER_BIT`=5208
- Sub-module `uart_rr_pick`: combinational round-robin priority picker with inputs `req_vec` and `ptr`, outputs one-hot `gnt` and `gnt_idx`. Reused by future RX dispatch logic.

## Test plan
- Single request: `req_valid`=4'b0100, `req_data[23:16]`=8'hA5 → `req_ready`=4'b0100 at T, `tx_start` at T+1 with `tx_data`=8'hA5, `frame_done`=4'b0100 one cycle after `tx_done`, `grant_id`=2.
- All four valid continuously after reset → grant order 0,1,2,3,0. Each `tx_data` matches its requester's byte. Exactly one `tx_start` per frame.
- `tx_done` and new `req_valid[1]` in the same cycle → accept occurs at the next cycle. No overlapping `tx_start` while `tx_busy`=1.
- `rst_n` pulled low mid-frame (`grant_id`=3) → all outputs at reset values within the reset cycle. After release `ptr`=0, and requests 0 and 3 pending → requester 0 is granted first.
- With `UART_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100, `tx_done` held 0 → `timeout_err`=1 after 100 cycles in WAIT_DONE, `frame_done` pulses, and the next request is accepted.
- Loopback through real `uart_tx`/`uart_rx` with `CLKS_PER_BIT`=16, sending 8'h00, 8'hFF, 8'h5A from three requesters → `uart_rx` delivers the same bytes in round-robin order.
